fp_ldst_sequencer: RTL and testbench

FP_LDST_SEQUENCER -- requirements
Module: fp_ldst_sequencer

---
 rtl/fp_ldst_pkg.sv | 19 +
 rtl/fp_ldst_sequencer_if.sv | 40 ++++
 rtl/fp_ldst_addr_gen.sv | 14 +
 rtl/fp_ldst_sequencer.sv | 144 ++++++++++++++
 tb/tb_fp_ldst_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_ldst_pkg.sv
// Shared types and constants for the FP load/store sequencer.
// Holds the FSM state enum, active-low enable levels and the length-field width helper.
package fp_ldst_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic EN_ON  = 1'b0;
    localparam logic EN_OFF = 1'b1;

    // Width of the beats-minus-one field; a single-beat build still keeps one bit.
    function automatic int len_width(input int max_beats);
        return (max_beats <= 2) ? 1 : $clog2(max_beats);
    endfunction

endpackage

// File: rtl/fp_ldst_sequencer_if.sv
// Request, data-memory and FP-register-file signals of the load/store sequencer.
// master = the sequencer, slave = requester plus memory and register file.
interface fp_ldst_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [LEN_W-1:0]  req_len;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_freg;
    logic              CEN;
    logic              WEN;
    logic              OEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Data2Mem;
    logic [DATA_W-1:0] ReadDataMem;
    logic [4:0]        fr_raddr;
    logic [DATA_W-1:0] fr_rdata;
    logic              fr_we;
    logic [4:0]        fr_waddr;
    logic [DATA_W-1:0] fr_wdata;
    logic              done;
    logic              busy;
    logic              err;

    modport master (
        input  req_valid, req_store, req_len, req_addr, req_freg, ReadDataMem, fr_rdata,
        output req_ready, CEN, WEN, OEN, A, Data2Mem, fr_raddr, fr_we, fr_waddr, fr_wdata,
               done, busy, err
    );

    modport slave (
        output req_valid, req_store, req_len, req_addr, req_freg, ReadDataMem, fr_rdata,
        input  req_ready, CEN, WEN, OEN, A, Data2Mem, fr_raddr, fr_we, fr_waddr, fr_wdata,
               done, busy, err
    );
endinterface

// File: rtl/fp_ldst_addr_gen.sv
// Per-beat memory word address and FP register index, both wrapping at their natural width.
module fp_ldst_addr_gen #(
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 2
) (
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [4:0]        base_freg_i,
    input  logic [LEN_W-1:0]  beat_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [4:0]        freg_o
);
    assign addr_o = base_addr_i + ADDR_W'(beat_i);
    assign freg_o = base_freg_i + 5'(beat_i);
endmodule

// File: rtl/fp_ldst_sequencer.sv
// Multi-beat FP register <-> data memory load/store sequencer (IDLE -> XFER -> DONE).
// Optional macro FP_LDST_ALIGN_CHK_EN rejects requests whose address or register base is not N-aligned.
//   state  | meaning
//   S_IDLE | waiting for a request, req_ready high
//   S_XFER | one memory beat per cycle, beat counter 0..len
//   S_DONE | no memory access, done pulse, last load writeback
module fp_ldst_sequencer
    import fp_ldst_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  ADDR_W    = 7,
    parameter int  MAX_BEATS = 4,
    localparam int LEN_W     = len_width(MAX_BEATS)
) (
    input logic                 clk,
    input logic                 rst,
    fp_ldst_sequencer_if.master bus
);
    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        freg_q, freg_d;
    logic              wb_pend_q, wb_pend_d;
    logic [4:0]        wb_idx_q, wb_idx_d;
    logic [ADDR_W-1:0] beat_addr;
    logic [4:0]        beat_freg;
    logic              accept;
    logic              misaligned;

    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    fp_ldst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .base_addr_i (addr_q),
        .base_freg_i (freg_q),
        .beat_i      (beat_q),
        .addr_o      (beat_addr),
        .freg_o      (beat_freg)
    );

`ifdef FP_LDST_ALIGN_CHK_EN
    localparam int NW = LEN_W + 1;
    logic [NW-1:0] n_req;
    logic          err_q;

    assign n_req      = NW'(bus.req_len) + NW'(1);
    assign misaligned = ((bus.req_addr % ADDR_W'(n_req)) != '0)
                     || ((bus.req_freg % 5'(n_req)) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept && misaligned;
    end
    assign bus.err = err_q;
`else
    assign misaligned = 1'b0;
    assign bus.err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            store_q   <= 1'b0;
            len_q     <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            freg_q    <= '0;
            wb_pend_q <= 1'b0;
            wb_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            freg_q    <= freg_d;
            wb_pend_q <= wb_pend_d;
            wb_idx_q  <= wb_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        len_d     = len_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        freg_d    = freg_q;
        wb_pend_d = 1'b0;
        wb_idx_d  = wb_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    store_d = bus.req_store;
                    len_d   = bus.req_len;
                    addr_d  = bus.req_addr;
                    freg_d  = bus.req_freg;
                    beat_d  = '0;
                    if (!misaligned) state_d = S_XFER;
                end
            end
            S_XFER: begin
                // Load data returns next cycle, so the writeback trails its beat by one.
                wb_pend_d = !store_q;
                wb_idx_d  = beat_freg;
                if (beat_q == len_q) state_d = S_DONE;
                else                 beat_d  = beat_q + LEN_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.CEN      = EN_OFF;
        bus.WEN      = EN_OFF;
        bus.OEN      = EN_OFF;
        bus.A        = '0;
        bus.Data2Mem = {DATA_W{1'b0}};
        bus.fr_raddr = '0;
        bus.fr_we    = wb_pend_q;
        bus.fr_waddr = wb_pend_q ? wb_idx_q : 5'd0;
        bus.fr_wdata = wb_pend_q ? bus.ReadDataMem : {DATA_W{1'b0}};
        bus.done     = (state_q == S_DONE);
        bus.busy     = (state_q != S_IDLE);
        if (state_q == S_XFER) begin
            bus.CEN = EN_ON;
            bus.A   = beat_addr;
            if (store_q) begin
                bus.WEN      = EN_ON;
                bus.fr_raddr = beat_freg;
                bus.Data2Mem = bus.fr_rdata;
            end else begin
                bus.OEN = EN_ON;
            end
        end
    end

endmodule

// File: tb/tb_fp_ldst_sequencer.sv
// Randomised bench for fp_ldst_sequencer: memory/register-file environment plus a transfer-level reference model.
module tb_fp_ldst_sequencer;
    localparam int DATA_W = 32, ADDR_W = 7, MAX_BEATS = 4, LEN_W = 2, DEPTH = 128;
`ifdef FP_LDST_ALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct { int cyc; logic wr; logic [ADDR_W-1:0] a; logic [31:0] d; } mem_ev_t;
    typedef struct { int cyc; logic [4:0] r; logic [31:0] d; } wb_ev_t;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   cyc = 0;
    int   n_cmp = 0, n_mis = 0;
    int   busy_cnt;

    logic [31:0] mem [DEPTH];
    logic [31:0] fregs [32];
    logic [31:0] mem_init [DEPTH];
    logic [31:0] freg_init [32];
    logic [31:0] rdata_q;

    mem_ev_t mem_log[$];
    wb_ev_t  wb_log[$];
    int      done_log[$], err_log[$], acc_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_ldst_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    fp_ldst_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.ReadDataMem = rdata_q;
    assign bus.fr_rdata    = fregs[bus.fr_raddr];

    always @(posedge clk) begin
        if (preload) begin
            mem   <= mem_init;
            fregs <= freg_init;
        end else begin
            if (bus.CEN === 1'b0 && bus.WEN === 1'b0) mem[bus.A] <= bus.Data2Mem;
            if (bus.CEN === 1'b0 && bus.OEN === 1'b0) rdata_q <= mem[bus.A];
            if (bus.fr_we === 1'b1) fregs[bus.fr_waddr] <= bus.fr_wdata;
        end
    end

    always @(negedge clk) begin
        #2;
        if (bus.CEN === 1'b0)
            mem_log.push_back('{cyc, (bus.WEN === 1'b0), bus.A, (bus.WEN === 1'b0) ? bus.Data2Mem : 32'h0});
        if (bus.fr_we === 1'b1) wb_log.push_back('{cyc, bus.fr_waddr, bus.fr_wdata});
        if (bus.done === 1'b1) done_log.push_back(cyc);
        if (bus.err === 1'b1) err_log.push_back(cyc);
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) acc_log.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        mem_log.delete(); wb_log.delete(); done_log.delete(); err_log.delete(); acc_log.delete();
        busy_cnt = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem_init[i] = $urandom;
        for (int i = 0; i < 32; i++) freg_init[i] = $urandom;
    endtask

    task automatic do_preload();
        @(negedge clk) preload = 1'b1;
        @(negedge clk) preload = 1'b0;
    endtask

    task automatic drive_req(input logic st, input int len, input int addr, input int freg);
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_len   = LEN_W'(len);
        bus.req_addr  = ADDR_W'(addr);
        bus.req_freg  = 5'(freg);
    endtask

    // One request; expectations come from the transfer rules, applied to the preloaded images.
    task automatic run_xfer(input logic st, input int len, input int addr, input int freg);
        int n, t, a, r, nbad;
        bit exp_err;
        logic [31:0] exp_mem [DEPTH];
        logic [31:0] exp_freg [32];
        n = len + 1;
        exp_err  = CHK_EN && (((addr % n) != 0) || ((freg % n) != 0));
        exp_mem  = mem_init;
        exp_freg = freg_init;
        if (!exp_err)
            for (int i = 0; i < n; i++) begin
                a = (addr + i) % DEPTH;
                r = (freg + i) % 32;
                if (st) exp_mem[a] = freg_init[r];
                else    exp_freg[r] = mem_init[a];
            end
        clear_logs();
        @(negedge clk);
        drive_req(st, len, addr, freg);
        t = cyc;
        // Random request noise while busy must be ignored.
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (exp_err) bus.req_valid = 1'b0;
            else drive_req($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 31));
        end
        @(negedge clk) bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #5;
        chk("accept_cnt", acc_log.size(), 1);
        if (acc_log.size() > 0) chk("accept_cyc", acc_log[0], t);
        chk("beat_cnt", mem_log.size(), exp_err ? 0 : n);
        for (int k = 0; k < mem_log.size() && k < n; k++) begin
            chk("beat_cyc", mem_log[k].cyc, t + 1 + k);
            chk("beat_wr", mem_log[k].wr, st);
            chk("beat_addr", mem_log[k].a, (addr + k) % DEPTH);
            chk("beat_data", mem_log[k].d, st ? freg_init[(freg + k) % 32] : 32'h0);
        end
        chk("wb_cnt", wb_log.size(), (exp_err || st) ? 0 : n);
        for (int k = 0; k < wb_log.size() && k < n; k++) begin
            chk("wb_cyc", wb_log[k].cyc, t + 2 + k);
            chk("wb_reg", wb_log[k].r, (freg + k) % 32);
            chk("wb_data", wb_log[k].d, mem_init[(addr + k) % DEPTH]);
        end
        chk("done_cnt", done_log.size(), exp_err ? 0 : 1);
        if (done_log.size() > 0) chk("done_cyc", done_log[0], t + n + 1);
        chk("err_cnt", err_log.size(), exp_err ? 1 : 0);
        if (err_log.size() > 0) chk("err_cyc", err_log[0], t + 1);
        chk("busy_cycles", busy_cnt, exp_err ? 0 : n + 1);
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) nbad++;
        chk("mem_image_bad", nbad, 0);
        nbad = 0;
        for (int i = 0; i < 32; i++) if (fregs[i] !== exp_freg[i]) nbad++;
        chk("freg_image_bad", nbad, 0);
    endtask

    // Request held valid: the second acceptance must land exactly N+2 cycles after the first.
    task automatic run_b2b(input int len);
        int n, budget;
        n = len + 1;
        clear_logs();
        @(negedge clk);
        drive_req(1'b1, len, 0, 0);
        budget = 0;
        while (acc_log.size() < 2 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        bus.req_valid = 1'b0;
        repeat (n + 3) @(negedge clk);
        #5;
        chk("b2b_accept_cnt", acc_log.size(), 2);
        if (acc_log.size() >= 2) chk("b2b_gap", acc_log[1] - acc_log[0], n + 2);
        chk("b2b_beats", mem_log.size(), 2 * n);
        chk("b2b_done_cnt", done_log.size(), 2);
    endtask

    // Reset lands once beat 0's writeback has committed, while the load is still mid-flight.
    task automatic run_reset_abort();
        fill_random();
        do_preload();
        clear_logs();
        @(negedge clk);
        drive_req(1'b0, 3, 'h20, 8);
        @(negedge clk) bus.req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_cen", bus.CEN, 1'b1);
        chk("abort_oen", bus.OEN, 1'b1);
        chk("abort_addr", bus.A, 0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_ready", bus.req_ready, 1'b0);
        chk("abort_fr_we", bus.fr_we, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #5;
        chk("abort_reads", mem_log.size(), 2);
        chk("abort_wb_cnt", wb_log.size(), 1);
        if (wb_log.size() > 0) begin
            chk("abort_wb_reg", wb_log[0].r, 8);
            chk("abort_wb_data", wb_log[0].d, mem_init['h20]);
        end
        chk("abort_f9_kept", fregs[9], freg_init[9]);
        chk("abort_done_cnt", done_log.size(), 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_store = 1'b0;
        bus.req_len   = '0;
        bus.req_addr  = '0;
        bus.req_freg  = '0;
        preload       = 1'b0;
        rst           = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_cen", bus.CEN, 1'b1);
        chk("rst_wen", bus.WEN, 1'b1);
        chk("rst_oen", bus.OEN, 1'b1);
        chk("rst_addr", bus.A, 0);
        chk("rst_d2m", bus.Data2Mem, 0);
        chk("rst_fr_we", bus.fr_we, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1'b1);

        fill_random();
        freg_init[4] = 32'h3F800000;
        freg_init[5] = 32'h40000000;
        do_preload();
        run_xfer(1'b1, 1, 'h10, 4);

        fill_random();
        mem_init['h7E] = 32'd1;
        mem_init['h7F] = 32'd2;
        mem_init['h00] = 32'd3;
        mem_init['h01] = 32'd4;
        do_preload();
        run_xfer(1'b0, 3, 'h7E, 8);

        fill_random();
        do_preload();
        run_xfer(1'b0, 3, 'h40, 30);

        fill_random();
        do_preload();
        run_xfer(1'b1, 1, 'h00, 3);

        run_b2b(0);
        run_b2b($urandom_range(1, 3));
        run_reset_abort();

        for (int t = 0; t < 24; t++) begin
            fill_random();
            do_preload();
            run_xfer($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 31));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
